// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, whole-word memory accesses,
// lane extraction for loads and read-modify-write for byte/half stores.
module lsu_mem_initiator #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [31:0] MAX_BASE = 32'(MEM_BYTES - 4);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wword_q;
  logic [2:0]  funct3_q;
  logic        we_q;

  logic        accept;
  logic        req_err;
  logic [4:0]  sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;
  logic [31:0] merge_mask;
  logic [31:0] merge_data;
  logic [31:0] merged;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Screen the raw request so an erroneous one goes straight to RESP.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'd2) req_err = 1'b1;
    end else begin
      if (req_funct3 == 3'd3 || req_funct3 > 3'd5) req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'd1 && req_addr[0]) req_err = 1'b1;
    if (req_funct3 == 3'd2 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({req_addr[31:2], 2'b00} > MAX_BASE) req_err = 1'b1;
  end

  // Big-endian lanes: lane 0 is the top byte of the word.
  assign sh     = {addr_q[1:0], 3'b000};
  assign byte_v = 8'(mem_rdata >> (5'd24 - sh));
  assign half_v = 16'(mem_rdata >> (5'd16 - sh));

  always_comb begin
    load_ext = mem_rdata;
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_v[7]}}, byte_v};
      3'd1:    load_ext = {{16{half_v[15]}}, half_v};
      3'd4:    load_ext = {24'h0, byte_v};
      3'd5:    load_ext = {16'h0, half_v};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    if (funct3_q[1:0] == 2'd0) begin
      merge_mask = 32'hFF00_0000 >> sh;
      merge_data = {wdata_q[7:0], 24'h0} >> sh;
    end else begin
      merge_mask = 32'hFFFF_0000 >> sh;
      merge_data = {wdata_q[15:0], 16'h0} >> sh;
    end
    merged = (mem_rdata & ~merge_mask) | merge_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wword_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wword_q  <= req_wdata;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_we && req_funct3 == 3'd2) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            wword_q <= merged;
            state   <= WR;
          end else begin
            resp_rdata <= load_ext;
            state      <= RESP;
          end
        end
        WR: state <= RESP;
        default: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign mem_we     = (state == WR) && !reset;
  assign mem_addr   = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = (state == WR) ? wword_q : 32'h0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a byte-array memory model and a
// response scoreboard.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [0:1023];
  logic        mem_clear;
  logic [9:0]  idx;

  logic [32:0] sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  lsu_mem_initiator #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Big-endian byte memory with combinational read.
  assign idx = mem_addr[9:0];
  always_comb mem_rdata = {mem[idx], mem[idx + 10'd1], mem[idx + 10'd2], mem[idx + 10'd3]};

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[idx]         <= mem_wdata[31:24];
      mem[idx + 10'd1] <= mem_wdata[23:16];
      mem[idx + 10'd2] <= mem_wdata[15:8];
      mem[idx + 10'd3] <= mem_wdata[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [32:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, e[32]});
      chk({tag, "_rdata"}, resp_rdata, e[31:0]);
    end
  endtask

  // Called just after a negedge; returns just after the negedge of the response cycle.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic eerr, input logic [31:0] erdata, input int elat);
    int lat, we_cnt, we_at, busy_bad;
    logic [31:0] a1;
    sb_q.push_back({eerr, erdata});
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we_cnt = 0; we_at = -1; busy_bad = 0; a1 = 32'hx;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) a1 = mem_addr;
      if (req_ready) busy_bad++;
      if (mem_we) begin
        we_cnt++;
        if (we_at < 0) we_at = n;
      end
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, lat, elat);
    checkOutput(tag);
    chk({tag, "_busy_ready"}, busy_bad, 0);
    chk({tag, "_memaddr"}, a1, eerr ? 32'h0 : {addr[31:2], 2'b00});
    if (we && !eerr) begin
      chk({tag, "_we_cycles"}, we_cnt, 1);
      chk({tag, "_we_at"}, we_at, elat - 1);
    end else begin
      chk({tag, "_we_cycles"}, we_cnt, 0);
    end
  endtask

  initial begin
    int n_acc, bad;
    reset = 1'b1; mem_clear = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; mem_clear = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, req_ready}, 32'd1);

    applyStimulus("sw10",   1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0, 2);
    applyStimulus("lw10",   1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h11223344, 2);
    applyStimulus("lb10",   1'b0, 3'd0, 32'h10, 32'h0, 1'b0, 32'h00000011, 2);
    applyStimulus("lbu13",  1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 32'h00000044, 2);
    applyStimulus("sb11",   1'b1, 3'd0, 32'h11, 32'h00000080, 1'b0, 32'h0, 3);
    applyStimulus("lw10b",  1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h11803344, 2);
    applyStimulus("lb11",   1'b0, 3'd0, 32'h11, 32'h0, 1'b0, 32'hFFFFFF80, 2);
    applyStimulus("lbu11",  1'b0, 3'd4, 32'h11, 32'h0, 1'b0, 32'h00000080, 2);
    applyStimulus("sh12",   1'b1, 3'd1, 32'h12, 32'h0000BEEF, 1'b0, 32'h0, 3);
    applyStimulus("lw10c",  1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h1180BEEF, 2);
    applyStimulus("lh12",   1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 32'hFFFFBEEF, 2);
    applyStimulus("lhu12",  1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 32'h0000BEEF, 2);
    applyStimulus("lh10",   1'b0, 3'd1, 32'h10, 32'h0, 1'b0, 32'h00001180, 2);

    applyStimulus("err_lh11",  1'b0, 3'd1, 32'h11,  32'h0, 1'b1, 32'h0, 1);
    applyStimulus("err_lw12",  1'b0, 3'd2, 32'h12,  32'h0, 1'b1, 32'h0, 1);
    applyStimulus("err_sw3fe", 1'b1, 3'd2, 32'h3FE, 32'hDEADBEEF, 1'b1, 32'h0, 1);
    applyStimulus("err_lw400", 1'b0, 3'd2, 32'h400, 32'h0, 1'b1, 32'h0, 1);
    applyStimulus("err_ld_f3", 1'b0, 3'd3, 32'h10,  32'h0, 1'b1, 32'h0, 1);
    applyStimulus("err_st_f4", 1'b1, 3'd4, 32'h10,  32'h0, 1'b1, 32'h0, 1);
    applyStimulus("lw3fc",     1'b0, 3'd2, 32'h3FC, 32'h0, 1'b0, 32'h0, 2);
    applyStimulus("lw10_after_err", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h1180BEEF, 2);

    // Back-to-back: req_valid held across SW then LW.
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    sb_q.push_back({1'b0, 32'h0});
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 32'h0;
    sb_q.push_back({1'b0, 32'hCAFEF00D});
    n_acc = 0; bad = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        chk("b2b_sw_resp_at", n, 2);
        checkOutput("b2b_sw");
      end
      if (req_ready) begin
        n_acc = n;
        break;
      end
    end
    chk("b2b_second_accept", n_acc, 3);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_acc = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (req_ready) bad++;
      if (resp_valid) begin
        n_acc = n;
        break;
      end
    end
    chk("b2b_lw_latency", n_acc, 2);
    checkOutput("b2b_lw");
    chk("b2b_lw_busy_ready", bad, 0);

    // Reset during the RD cycle of an SB must leave memory untouched.
    applyStimulus("sw10_restore", 1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0, 2);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h000000AA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rstmid_mem_we", {31'h0, mem_we}, 32'd0);
    chk("rstmid_ready", {31'h0, req_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) chk("rstmid_ready_after", {31'h0, req_ready}, 32'd1);
      if (resp_valid || mem_we) bad++;
    end
    chk("rstmid_no_activity", bad, 0);
    applyStimulus("lw10_after_rst", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h11223344, 2);

    chk("sb_queue_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
